// File: rtl/usb_cdc_cmd_responder_if.sv
// Byte-stream bundle between usb_cdc and the command responder.
// The OUT stream carries host command bytes toward the responder.
// The IN stream carries reply bytes back toward the host.
// master = usb_cdc side, slave = responder side.
interface usb_cdc_cmd_responder_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data_i;
    logic              out_valid_i;
    logic              out_ready_o;
    logic [DATA_W-1:0] in_data_o;
    logic              in_valid_o;
    logic              in_ready_i;

    modport master (
        output out_data_i, out_valid_i, in_ready_i,
        input  out_ready_o, in_data_o, in_valid_o
    );

    modport slave (
        input  out_data_i, out_valid_i, in_ready_i,
        output out_ready_o, in_data_o, in_valid_o
    );
endinterface

// File: rtl/usb_cdc_cmd_responder.sv
// Host register-access responder on the usb_cdc byte streams.
// Parses W/R/? commands from the OUT stream and acts on a small register file.
// Returns exactly one reply byte per completed command on the IN stream.
// A command left stalled mid-way for TIMEOUT cycles is dropped silently.
module usb_cdc_cmd_responder #(
    parameter int unsigned NREGS   = 4,
    parameter logic [7:0]  REG_RST = 8'h00,
    parameter logic [7:0]  ID_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT = 48000
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   configured_i,
    usb_cdc_cmd_responder_if.slave cdc,
    output logic [8*NREGS-1:0]     regs_o
);

    localparam int DATA_W = 8;
    localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [DATA_W-1:0] OP_WR   = 8'h57;
    localparam logic [DATA_W-1:0] OP_RD   = 8'h52;
    localparam logic [DATA_W-1:0] OP_PING = 8'h3F;
    localparam logic [DATA_W-1:0] ACK     = 8'h06;
    localparam logic [DATA_W-1:0] NAK     = 8'h15;
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t            state;
    logic              is_wr;
    logic [DATA_W-1:0] addr;
    logic [TW-1:0]     tmo_cnt;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] regs [NREGS];

    logic              out_fire;
    logic              tmo_hit;
    logic [TW-1:0]     tmo_next;

    function automatic logic addr_ok(input logic [DATA_W-1:0] a);
        return 32'(a) < NREGS;
    endfunction

    // Out-of-range addresses read back as NAK, which is exactly the reply wanted.
    function automatic logic [DATA_W-1:0] reg_rd(input logic [DATA_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = NAK;
        for (int k = 0; k < NREGS; k++) begin
            if (a == DATA_W'(k)) v = regs[k];
        end
        return v;
    endfunction

    assign cdc.out_ready_o = configured_i && (state != RESP);
    assign cdc.in_data_o   = in_data;
    assign cdc.in_valid_o  = in_valid;

    assign out_fire = cdc.out_valid_i && cdc.out_ready_o;
    assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    assign tmo_next = (TIMEOUT == 0) ? tmo_cnt : tmo_cnt + TW'(1);

    for (genvar k = 0; k < NREGS; k++) begin : g_pack
        assign regs_o[8*k +: 8] = regs[k];
    end

    // Command FSM: byte parsing, register writes, reply register and stall timeout.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            is_wr    <= 1'b0;
            addr     <= '0;
            tmo_cnt  <= '0;
            in_data  <= '0;
            in_valid <= 1'b0;
            for (int k = 0; k < NREGS; k++) regs[k] <= REG_RST;
        end else if (!configured_i) begin
            // Link lost: drop any partial command or pending reply, keep registers.
            state    <= IDLE;
            in_valid <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_fire) begin
                        tmo_cnt <= '0;
                        case (cdc.out_data_i)
                            OP_WR: begin
                                is_wr <= 1'b1;
                                state <= ADDR;
                            end
                            OP_RD: begin
                                is_wr <= 1'b0;
                                state <= ADDR;
                            end
                            OP_PING: begin
                                in_data  <= ID_BYTE;
                                in_valid <= 1'b1;
                                state    <= RESP;
                            end
                            default: begin
                                in_data  <= NAK;
                                in_valid <= 1'b1;
                                state    <= RESP;
                            end
                        endcase
                    end
                end
                ADDR: begin
                    if (out_fire) begin
                        addr    <= cdc.out_data_i;
                        tmo_cnt <= '0;
                        if (is_wr) begin
                            state <= DATA;
                        end else begin
                            in_data  <= reg_rd(cdc.out_data_i);
                            in_valid <= 1'b1;
                            state    <= RESP;
                        end
                    end else if (tmo_hit) begin
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                DATA: begin
                    if (out_fire) begin
                        tmo_cnt <= '0;
                        for (int k = 0; k < NREGS; k++) begin
                            if (addr == DATA_W'(k)) regs[k] <= cdc.out_data_i;
                        end
                        in_data  <= addr_ok(addr) ? ACK : NAK;
                        in_valid <= 1'b1;
                        state    <= RESP;
                    end else if (tmo_hit) begin
                        tmo_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                RESP: begin
                    if (cdc.in_ready_i) begin
                        in_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
